// File: rtl/mem_stream_reader_pkg.sv
// Shared types and constants for the memory stream reader.
package mem_stream_reader_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StLatch,
        StSend,
        StFinish
    } state_e;

endpackage

// File: rtl/mem_stream_reader.sv
// Sweeps a 1-cycle registered memory over an inclusive, wrapping address range and
// hands each byte to a valid/ready consumer.
module mem_stream_reader #(
    parameter bit          STOP_ON_NUL = 1'b1,
    parameter int unsigned ADDR_W      = mem_stream_reader_pkg::ADDR_W
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic [ADDR_W-1:0]                       start_addr,
    input  logic [ADDR_W-1:0]                       end_addr,
    output logic [ADDR_W-1:0]                       address,
    input  logic [mem_stream_reader_pkg::DATA_W-1:0] value,
    output logic [mem_stream_reader_pkg::DATA_W-1:0] byte_out,
    output logic                                    byte_valid,
    input  logic                                    byte_ready,
    output logic                                    busy,
    output logic                                    done
);

    import mem_stream_reader_pkg::*;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cur_addr_q <= '0;
            end_addr_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        data_d     = data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StIssue;
                    cur_addr_d = start_addr;
                    end_addr_d = end_addr;
                end
            end
            StIssue: begin
                state_d = abort ? StFinish : StLatch;
            end
            StLatch: begin
                // Memory output now belongs to cur_addr_q, presented since ISSUE.
                data_d = value;
                if (abort) begin
                    state_d = StFinish;
                end else if (STOP_ON_NUL && (value == '0)) begin
                    state_d = StFinish;
                end else begin
                    state_d = StSend;
                end
            end
            StSend: begin
                // Abort wins over a simultaneous handshake; the byte is dropped.
                if (abort) begin
                    state_d = StFinish;
                end else if (byte_ready) begin
                    if (cur_addr_q == end_addr_q) begin
                        state_d = StFinish;
                    end else begin
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                        state_d    = StIssue;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        address    = '0;
        byte_out   = '0;
        byte_valid = 1'b0;
        unique case (state_q)
            StIssue, StLatch: begin
                address = cur_addr_q;
            end
            StSend: begin
                address    = cur_addr_q;
                byte_out   = data_q;
                byte_valid = 1'b1;
            end
            default: begin
                address = '0;
            end
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StFinish);

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed scoreboard bench for mem_stream_reader against a 1-cycle registered ROM.
module tb_mem_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       start0, start1;
    logic       abort;
    logic [4:0] start_addr, end_addr;
    logic       ready;

    logic [4:0] addr0, addr1;
    logic [7:0] val0, val1;
    logic [7:0] bo0, bo1;
    logic       bv0, bv1, busy0, busy1, done0, done1;

    logic [7:0] rom [32];
    logic [7:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    logic [4:0] o_addr;
    logic [7:0] o_byte;
    logic       o_valid, o_busy, o_done;

    mem_stream_reader #(.STOP_ON_NUL(1'b1), .ADDR_W(5)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr), .address(addr0), .value(val0),
        .byte_out(bo0), .byte_valid(bv0), .byte_ready(ready), .busy(busy0), .done(done0)
    );

    mem_stream_reader #(.STOP_ON_NUL(1'b0), .ADDR_W(5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr), .address(addr1), .value(val1),
        .byte_out(bo1), .byte_valid(bv1), .byte_ready(ready), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        val0 <= rom[addr0];
        val1 <= rom[addr1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            o_addr = addr0; o_byte = bo0; o_valid = bv0; o_busy = busy0; o_done = done0;
        end else begin
            o_addr = addr1; o_byte = bo1; o_valid = bv1; o_busy = busy1; o_done = done1;
        end
    endtask

    task automatic step(input int sel);
        @(negedge clk);
        sample(sel);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Runs from the current negedge until done; handshakes pop the scoreboard.
    task automatic run_sweep(input int sel, input string tag, input int exp_bytes,
                             input int exp_busy, input bit chk_timing);
        int cyc = 0, nb = 0, bc = 0, last = -1, first = -1;
        bit fin = 1'b0;
        sample(sel);
        while (!fin && cyc < 400) begin
            if (o_busy) bc++;
            if (o_done) begin
                fin = 1'b1;
            end else if (o_valid && ready && !abort) begin
                nb++;
                if (first < 0) first = cyc;
                if (chk_timing && last >= 0) chk({tag, " gap"}, cyc - last, 3);
                last = cyc;
                if (exp_q.size() > 0) chk({tag, " byte"}, {24'd0, o_byte}, {24'd0, exp_q.pop_front()});
            end
            if (!fin) begin
                step(sel);
                cyc++;
                start0 = 1'b0;
                start1 = 1'b0;
            end
        end
        chk({tag, " done seen"}, {31'd0, fin}, 1);
        chk({tag, " count"}, nb, exp_bytes);
        chk({tag, " queue empty"}, exp_q.size(), 0);
        if (exp_busy > 0) chk({tag, " busy cycles"}, bc, exp_busy);
        if (chk_timing) chk({tag, " latency"}, first, 3);
        step(sel);
        chk({tag, " done pulse ends"}, {31'd0, o_done}, 0);
        chk({tag, " idle after"}, {31'd0, o_busy}, 0);
    endtask

    initial begin
        string s;
        int    n;
        s = "fun{speedsterr}";
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) rom[i] = s[i];
        rom[31] = "L";

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
        start_addr = '0; end_addr = '0; ready = 1'b1;
        #12;
        sample(0);
        chk("rst address", {27'd0, o_addr}, 0);
        chk("rst byte_out", {24'd0, o_byte}, 0);
        chk("rst valid", {31'd0, o_valid}, 0);
        chk("rst busy", {31'd0, o_busy}, 0);
        chk("rst done", {31'd0, o_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0);

        // abort while idle is ignored
        abort = 1'b1;
        step(0);
        abort = 1'b0;
        chk("idle abort busy", {31'd0, o_busy}, 0);
        step(0);
        chk("idle abort done", {31'd0, o_done}, 0);

        push_str("fun{speedsterr}");
        start_addr = 5'd0; end_addr = 5'd14; start0 = 1'b1;
        run_sweep(0, "full", 15, 46, 1'b1);

        push_str("terr}");
        start_addr = 5'd10; end_addr = 5'd20; start0 = 1'b1;
        run_sweep(0, "nul stop", 5, 18, 1'b1);

        push_str("Lfu");
        start_addr = 5'd31; end_addr = 5'd1; start1 = 1'b1;
        run_sweep(1, "wrap", 3, 10, 1'b1);

        push_str("p");
        start_addr = 5'd5; end_addr = 5'd5; start0 = 1'b1;
        run_sweep(0, "single", 1, 4, 1'b1);

        // Backpressure: hold ready low, byte and address must not move.
        ready = 1'b0;
        push_str("un");
        start_addr = 5'd1; end_addr = 5'd2; start0 = 1'b1;
        n = 0;
        do begin
            step(0);
            start0 = 1'b0;
            n++;
        end while (!o_valid && n < 20);
        chk("stall valid seen", {31'd0, o_valid}, 1);
        for (int i = 0; i < 10; i++) begin
            step(0);
            if (i == 5) start0 = 1'b0;
            chk("stall valid", {31'd0, o_valid}, 1);
            chk("stall byte", {24'd0, o_byte}, 32'h75);
            chk("stall addr", {27'd0, o_addr}, 1);
            if (i == 4) begin
                start_addr = 5'd0; end_addr = 5'd0; start0 = 1'b1;
            end
        end
        ready = 1'b1;
        run_sweep(0, "stall", 2, -1, 1'b0);

        // Abort coinciding with the second handshake.
        start_addr = 5'd0; end_addr = 5'd14; start0 = 1'b1;
        n = 0;
        do begin
            step(0);
            start0 = 1'b0;
            n++;
        end while (!o_valid && n < 10);
        chk("abort first byte", {24'd0, o_byte}, 32'h66);
        n = 0;
        do begin
            step(0);
            n++;
        end while (!o_valid && n < 10);
        chk("abort second byte", {24'd0, o_byte}, 32'h75);
        abort = 1'b1;
        step(0);
        abort = 1'b0;
        chk("abort done", {31'd0, o_done}, 1);
        chk("abort valid drop", {31'd0, o_valid}, 0);
        chk("abort finish busy", {31'd0, o_busy}, 1);
        step(0);
        chk("abort idle", {31'd0, o_busy}, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step(0);
            if (o_valid) n++;
        end
        chk("abort no more bytes", n, 0);

        // Reset asserted while in LATCH.
        start_addr = 5'd3; end_addr = 5'd5; start0 = 1'b1;
        step(0);
        start0 = 1'b0;
        step(0);
        chk("latch addr", {27'd0, o_addr}, 3);
        rst_n = 1'b0;
        #1;
        sample(0);
        chk("midrst address", {27'd0, o_addr}, 0);
        chk("midrst busy", {31'd0, o_busy}, 0);
        chk("midrst valid", {31'd0, o_valid}, 0);
        chk("midrst done", {31'd0, o_done}, 0);
        step(0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step(0);
            if (o_done) n++;
        end
        chk("midrst no done", n, 0);
        push_str("{sp");
        start_addr = 5'd3; end_addr = 5'd5; start0 = 1'b1;
        run_sweep(0, "after rst", 3, 10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter STOP_ON_NUL, default 1: when 1, a read byte of 8'h00 ends the sweep and is not emitted.
REQ-002 Parameter ADDR_W, default 5: memory address width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 abort  in  1  ends an active sweep at the next edge.
REQ-007 start_addr  in  ADDR_W  first address of sweep; captured at start.
REQ-008 end_addr  in  ADDR_W  last address of sweep, inclusive; captured at start.
REQ-009 address  out  ADDR_W  address driven to the 1-cycle registered memory.
REQ-010 value  in  8  memory read data; valid one edge after address is presented.
REQ-011 byte_out  out  8  captured byte for the downstream consumer (UART/display).
REQ-012 byte_valid  out  1  byte_out valid; held until accepted.
REQ-013 byte_ready  in  1  consumer accepts when byte_valid and byte_ready are both high at an edge.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 done  out  1  one-cycle pulse on return to IDLE after a completed or aborted sweep.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, ISSUE, LATCH, SEND, FINISH.
REQ-017 IDLE: start=1 -> ISSUE; cur_addr<=start_addr; end_addr is latched.
REQ-018 ISSUE: address=cur_addr for one full cycle -> LATCH.
REQ-019 LATCH: address held at cur_addr; data_reg<=value at the edge -> SEND. If STOP_ON_NUL and value==0 -> FINISH instead.
REQ-020 address SHALL be stable for both the ISSUE and LATCH cycles, so memory output and address always refer to the same location.
REQ-021 SEND: byte_valid=1 and byte_out=data_reg, both constant until handshake.
REQ-022 On handshake: if cur_addr==end_addr -> FINISH; else cur_addr<=cur_addr+1 (mod 2^ADDR_W) -> ISSUE.
REQ-023 Wrap-around: when end_addr<start_addr, the sweep SHALL continue through 31 and then 0. start_addr==end_addr reads exactly one byte. Maximum sweep length is 32 bytes.
REQ-024 FINISH lasts one cycle with done=1 -> IDLE.
REQ-025 abort=1 in ISSUE, LATCH or SEND -> FINISH at the next edge. Any pending byte is dropped and byte_valid falls.
REQ-026 abort has priority over the handshake in the same cycle.
REQ-027 start while busy SHALL be ignored. abort in IDLE or FINISH SHALL be ignored.
REQ-028 Throughput: 3 cycles per byte with byte_ready held high.
REQ-029 Latency: start edge to first byte_valid = 3 cycles.
REQ-030 In IDLE and FINISH, address SHALL be 0.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously go to IDLE, whatever the current state.
REQ-032 Reset values: address=0, byte_out=0, byte_valid=0, busy=0, done=0; cur_addr, end_addr and data_reg = 0.
REQ-033 Reset mid-sweep SHALL drop the pending byte with no done pulse. After release, the next start begins a fresh sweep.

Structure
REQ-034 The shared package SHALL hold the state enum (IDLE, ISSUE, LATCH, SEND, FINISH) and the constants ADDR_W=5 and DATA_W=8.
REQ-035 The block SHALL be a single module with no sub-module. Address counter and FSM stay inline.

Verification
REQ-036 The bench memory model is a 1-cycle registered ROM: "fun{speedsterr}" at 0..14, 0 at 15..30, "L" at 31.
REQ-037 start_addr=0, end_addr=14, STOP_ON_NUL=1, ready=1 -> bytes "fun{speedsterr}" in order, one every 3 cycles, then done pulse; busy high for 46 cycles.
REQ-038 start_addr=10, end_addr=20, STOP_ON_NUL=1 -> emits "terr}", stops at the NUL at address 15, done pulse, 5 bytes total.
REQ-039 start_addr=31, end_addr=1, STOP_ON_NUL=0 -> emits "L","f","u" (wrap 31->0->1), then done.
REQ-040 ready held low 10 cycles in SEND -> byte_valid, byte_out and address stable throughout; byte delivered once when ready rises.
REQ-041 abort asserted the same cycle as a handshake on byte 2 -> byte 2 not counted as delivered, FINISH next edge, done=1, no further bytes.
REQ-042 rst_n pulsed low in LATCH -> all outputs 0 immediately, no done; a new start then emits from start_addr correctly.
